// File: rtl/route_lookup_dispatcher.sv
// Router searcher front-end: issues lookups, pairs fixed-latency responses with
// their tags in issue order, and drains in-flight lookups before granting init.
//
// state | meaning
// RUN   | lookups accepted and issued
// DRAIN | issue blocked, waiting for in-flight lookups to resolve
// INIT  | table-load window granted (init_mode/cfg_init_ack high)
module route_lookup_dispatcher #(
    parameter int IP_WIDTH       = 32,
    parameter int TAG_WIDTH      = 16,
    parameter int LOOKUP_LATENCY = 3,
    parameter int DEPTH          = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [IP_WIDTH-1:0]  req_dst_ip,
    input  logic [TAG_WIDTH-1:0] req_tag,
    output logic                 lk_valid,
    output logic [IP_WIDTH-1:0]  lk_dst_ip,
    input  logic                 rsp_valid,
    input  logic                 rsp_found,
    input  logic [15:0]          rsp_out_port,
    input  logic [15:0]          rsp_out_qp,
    input  logic [47:0]          rsp_next_hop_mac,
    input  logic                 rsp_is_default_route,
    output logic                 fwd_valid,
    input  logic                 fwd_ready,
    output logic [TAG_WIDTH-1:0] fwd_tag,
    output logic                 fwd_found,
    output logic                 fwd_is_default,
    output logic                 fwd_err,
    output logic [15:0]          fwd_out_port,
    output logic [15:0]          fwd_out_qp,
    output logic [47:0]          fwd_next_hop_mac,
    input  logic                 cfg_init_req,
    output logic                 cfg_init_ack,
    output logic                 init_mode,
    output logic [15:0]          lost_cnt,
    output logic [15:0]          spurious_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] DEPTH_P = (PW+1)'(DEPTH);
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_INIT} state_t;

    state_t r_state;
    state_t w_state_next;

    logic [PW:0]               r_wr_ptr;
    logic [PW:0]               r_rs_ptr;
    logic [PW:0]               r_rd_ptr;
    logic [PW:0]               w_occ;
    logic [PW-1:0]             w_wr_idx;
    logic [PW-1:0]             w_rs_idx;
    logic [PW-1:0]             w_rd_idx;
    logic [TAG_WIDTH-1:0]      r_tag   [DEPTH];
    logic                      r_found [DEPTH];
    logic                      r_dflt  [DEPTH];
    logic                      r_err   [DEPTH];
    logic [15:0]               r_port  [DEPTH];
    logic [15:0]               r_qp    [DEPTH];
    logic [47:0]               r_mac   [DEPTH];
    logic [LOOKUP_LATENCY-1:0] r_exp_sr;
    logic                      r_lk_valid;
    logic [IP_WIDTH-1:0]       r_lk_dst_ip;
    logic [15:0]               r_lost_cnt;
    logic [15:0]               r_spur_cnt;
    logic                      r_init_mode;
    logic                      r_init_ack;
    logic                      w_accept;
    logic                      w_due;
    logic                      w_pop;
    logic                      w_drained;

    assign w_occ     = r_wr_ptr - r_rd_ptr;
    assign w_wr_idx  = r_wr_ptr[PW-1:0];
    assign w_rs_idx  = r_rs_ptr[PW-1:0];
    assign w_rd_idx  = r_rd_ptr[PW-1:0];
    assign req_ready = (r_state == S_RUN) && !cfg_init_req && (w_occ < DEPTH_P);
    assign w_accept  = req_valid && req_ready;
    assign w_due     = r_exp_sr[LOOKUP_LATENCY-1];
    assign fwd_valid = (r_rs_ptr != r_rd_ptr);
    assign w_pop     = fwd_valid && fwd_ready;
    assign w_drained = (r_exp_sr == '0) && !r_lk_valid;

    assign lk_valid         = r_lk_valid;
    assign lk_dst_ip        = r_lk_dst_ip;
    assign fwd_tag          = r_tag[w_rd_idx];
    assign fwd_found        = r_found[w_rd_idx];
    assign fwd_is_default   = r_dflt[w_rd_idx];
    assign fwd_err          = r_err[w_rd_idx];
    assign fwd_out_port     = r_port[w_rd_idx];
    assign fwd_out_qp       = r_qp[w_rd_idx];
    assign fwd_next_hop_mac = r_mac[w_rd_idx];
    assign lost_cnt         = r_lost_cnt;
    assign spurious_cnt     = r_spur_cnt;
    assign init_mode        = r_init_mode;
    assign cfg_init_ack     = r_init_ack;

    // A due cycle without rsp_valid still resolves its slot (as an error) so
    // later responses stay paired with the right tags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_rs_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_exp_sr    <= '0;
            r_lk_valid  <= 1'b0;
            r_lk_dst_ip <= '0;
            r_lost_cnt  <= '0;
            r_spur_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i]   <= '0;
                r_found[i] <= 1'b0;
                r_dflt[i]  <= 1'b0;
                r_err[i]   <= 1'b0;
                r_port[i]  <= '0;
                r_qp[i]    <= '0;
                r_mac[i]   <= '0;
            end
        end else begin
            r_lk_valid <= w_accept;
            r_exp_sr   <= (r_exp_sr << 1) | LOOKUP_LATENCY'(r_lk_valid);
            if (w_accept) begin
                r_tag[w_wr_idx] <= req_tag;
                r_lk_dst_ip     <= req_dst_ip;
                r_wr_ptr        <= r_wr_ptr + PTR_ONE;
            end
            if (w_due) begin
                r_found[w_rs_idx] <= rsp_valid && rsp_found;
                r_dflt[w_rs_idx]  <= rsp_valid && rsp_is_default_route;
                r_err[w_rs_idx]   <= !rsp_valid;
                r_port[w_rs_idx]  <= rsp_valid ? rsp_out_port : 16'd0;
                r_qp[w_rs_idx]    <= rsp_valid ? rsp_out_qp : 16'd0;
                r_mac[w_rs_idx]   <= rsp_valid ? rsp_next_hop_mac : 48'd0;
                r_rs_ptr          <= r_rs_ptr + PTR_ONE;
                if (!rsp_valid && (r_lost_cnt != 16'hFFFF))
                    r_lost_cnt <= r_lost_cnt + 16'd1;
            end else if (rsp_valid && (r_spur_cnt != 16'hFFFF)) begin
                r_spur_cnt <= r_spur_cnt + 16'd1;
            end
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN: begin
                if (cfg_init_req)
                    w_state_next = S_DRAIN;
            end
            S_DRAIN: begin
                if (!cfg_init_req)
                    w_state_next = S_RUN;
                else if (w_drained)
                    w_state_next = S_INIT;
            end
            S_INIT: begin
                if (!cfg_init_req)
                    w_state_next = S_RUN;
            end
            default: w_state_next = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_RUN;
            r_init_mode <= 1'b0;
            r_init_ack  <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_init_mode <= (w_state_next == S_INIT);
            r_init_ack  <= (w_state_next == S_INIT);
        end
    end
endmodule

// File: tb/tb_route_lookup_dispatcher.sv
// Randomized scoreboard bench for route_lookup_dispatcher: a transaction-level
// model predicts handshakes, the init window, counters and forwarded results.
`timescale 1ns/1ps
module tb_route_lookup_dispatcher;
    localparam int IPW   = 32;
    localparam int TW    = 16;
    localparam int LAT   = 3;
    localparam int DEPTH = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           req_valid = 1'b0;
    logic           req_ready;
    logic [IPW-1:0] req_dst_ip = '0;
    logic [TW-1:0]  req_tag = '0;
    logic           lk_valid;
    logic [IPW-1:0] lk_dst_ip;
    logic           rsp_valid = 1'b0;
    logic           rsp_found = 1'b0;
    logic [15:0]    rsp_out_port = '0;
    logic [15:0]    rsp_out_qp = '0;
    logic [47:0]    rsp_next_hop_mac = '0;
    logic           rsp_is_default_route = 1'b0;
    logic           fwd_valid;
    logic           fwd_ready = 1'b0;
    logic [TW-1:0]  fwd_tag;
    logic           fwd_found;
    logic           fwd_is_default;
    logic           fwd_err;
    logic [15:0]    fwd_out_port;
    logic [15:0]    fwd_out_qp;
    logic [47:0]    fwd_next_hop_mac;
    logic           cfg_init_req = 1'b0;
    logic           cfg_init_ack;
    logic           init_mode;
    logic [15:0]    lost_cnt;
    logic [15:0]    spurious_cnt;

    always #5 clk = ~clk;

    route_lookup_dispatcher #(
        .IP_WIDTH(IPW), .TAG_WIDTH(TW), .LOOKUP_LATENCY(LAT), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_dst_ip(req_dst_ip), .req_tag(req_tag),
        .lk_valid(lk_valid), .lk_dst_ip(lk_dst_ip),
        .rsp_valid(rsp_valid), .rsp_found(rsp_found),
        .rsp_out_port(rsp_out_port), .rsp_out_qp(rsp_out_qp),
        .rsp_next_hop_mac(rsp_next_hop_mac),
        .rsp_is_default_route(rsp_is_default_route),
        .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_tag(fwd_tag),
        .fwd_found(fwd_found), .fwd_is_default(fwd_is_default), .fwd_err(fwd_err),
        .fwd_out_port(fwd_out_port), .fwd_out_qp(fwd_out_qp),
        .fwd_next_hop_mac(fwd_next_hop_mac),
        .cfg_init_req(cfg_init_req), .cfg_init_ack(cfg_init_ack),
        .init_mode(init_mode), .lost_cnt(lost_cnt), .spurious_cnt(spurious_cnt)
    );

    typedef struct {
        int            due;
        logic [TW-1:0] tag;
    } pend_t;

    typedef struct {
        logic [TW-1:0] tag;
        logic          found;
        logic          dflt;
        logic          err;
        logic [15:0]   port;
        logic [15:0]   qp;
        logic [47:0]   mac;
    } res_t;

    pend_t pend_q[$];
    res_t  res_q[$];

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    // model: 0 = normal issue, 1 = draining, 2 = init window granted
    int             m_state = 0;
    int             m_lost = 0;
    int             m_spur = 0;
    bit             prev_acc = 0;
    logic [IPW-1:0] prev_ip = '0;
    bit             acc_flag = 0;
    int             m_occ;
    bit             m_rdy, m_due, m_drained, m_acc, m_fv;
    res_t           m_r;
    pend_t          m_p;

    int p_req = 0, p_rdy = 100, p_drop = 0, p_spur = 0, p_cfg = 0;
    int drop_at = 0, rsp_num = 0;
    bit fix_req = 0, fix_rsp = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Monitor / scoreboard: samples mid-cycle, predicts what the coming edge does.
    always @(negedge clk) begin
        if (!rst_n) begin
            pend_q.delete();
            res_q.delete();
            m_state  = 0;
            m_lost   = 0;
            m_spur   = 0;
            prev_acc = 0;
            chk("rst_fwd_valid", fwd_valid, 0);
            chk("rst_lk_valid", lk_valid, 0);
            chk("rst_init_mode", init_mode, 0);
            chk("rst_ack", cfg_init_ack, 0);
            chk("rst_lost", lost_cnt, 0);
            chk("rst_spur", spurious_cnt, 0);
            chk("rst_fwd_tag", fwd_tag, 0);
            chk("rst_fwd_port", fwd_out_port, 0);
        end else begin
            m_occ = pend_q.size() + res_q.size();
            m_rdy = (m_state == 0) && !cfg_init_req && (m_occ < DEPTH);
            chk("req_ready", req_ready, m_rdy);
            chk("lk_valid", lk_valid, prev_acc);
            if (prev_acc)
                chk("lk_dst_ip", lk_dst_ip, prev_ip);
            chk("init_mode", init_mode, m_state == 2);
            chk("cfg_init_ack", cfg_init_ack, m_state == 2);
            chk("lost_cnt", lost_cnt, m_lost);
            chk("spurious_cnt", spurious_cnt, m_spur);

            m_fv = (res_q.size() > 0);
            chk("fwd_valid", fwd_valid, m_fv);
            if (m_fv) begin
                m_r = res_q[0];
                chk("fwd_tag", fwd_tag, m_r.tag);
                chk("fwd_found", fwd_found, m_r.found);
                chk("fwd_is_default", fwd_is_default, m_r.dflt);
                chk("fwd_err", fwd_err, m_r.err);
                chk("fwd_out_port", fwd_out_port, m_r.port);
                chk("fwd_out_qp", fwd_out_qp, m_r.qp);
                chk("fwd_mac", fwd_next_hop_mac, m_r.mac);
                if (fwd_ready)
                    void'(res_q.pop_front());
            end

            m_drained = (pend_q.size() == 0);
            m_due = (pend_q.size() > 0) && (pend_q[0].due == cyc);
            if (m_due) begin
                m_r.tag = pend_q[0].tag;
                void'(pend_q.pop_front());
                if (rsp_valid) begin
                    m_r.found = rsp_found;
                    m_r.dflt  = rsp_is_default_route;
                    m_r.err   = 1'b0;
                    m_r.port  = rsp_out_port;
                    m_r.qp    = rsp_out_qp;
                    m_r.mac   = rsp_next_hop_mac;
                end else begin
                    m_r.found = 1'b0;
                    m_r.dflt  = 1'b0;
                    m_r.err   = 1'b1;
                    m_r.port  = '0;
                    m_r.qp    = '0;
                    m_r.mac   = '0;
                    if (m_lost < 65535) m_lost++;
                end
                res_q.push_back(m_r);
            end else if (rsp_valid) begin
                if (m_spur < 65535) m_spur++;
            end

            m_acc = req_valid && m_rdy;
            if (m_acc) begin
                m_p.due = cyc + 1 + LAT;
                m_p.tag = req_tag;
                pend_q.push_back(m_p);
                acc_flag = 1;
                prev_ip  = req_dst_ip;
            end
            prev_acc = m_acc;

            case (m_state)
                0: if (cfg_init_req) m_state = 1;
                1: if (!cfg_init_req) m_state = 0;
                   else if (m_drained) m_state = 2;
                default: if (!cfg_init_req) m_state = 0;
            endcase
        end
    end

    // Driver and behavioural searcher: responds LAT+1 cycles after each accept.
    task automatic step();
        @(posedge clk);
        #1;
        if (!req_valid || acc_flag) begin
            acc_flag   = 0;
            req_valid  = ($urandom_range(99) < p_req);
            req_dst_ip = fix_req ? 32'h0A00_0001 : $urandom();
            req_tag    = fix_req ? 16'h0005 : 16'($urandom());
        end
        fwd_ready = ($urandom_range(99) < p_rdy);
        if ($urandom_range(999) < p_cfg)
            cfg_init_req = !cfg_init_req;
        rsp_found            = fix_rsp ? 1'b1 : 1'($urandom());
        rsp_is_default_route = fix_rsp ? 1'b0 : 1'($urandom());
        rsp_out_port         = fix_rsp ? 16'd2 : 16'($urandom());
        rsp_out_qp           = fix_rsp ? 16'h0011 : 16'($urandom());
        rsp_next_hop_mac     = fix_rsp ? 48'h0200_0000_0001 : {16'($urandom()), $urandom()};
        if ((pend_q.size() > 0) && (pend_q[0].due == cyc)) begin
            rsp_num++;
            rsp_valid = !((rsp_num == drop_at) || ($urandom_range(99) < p_drop));
        end else begin
            rsp_valid = ($urandom_range(99) < p_spur);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        rsp_valid    = 1'b0;
        cfg_init_req = 1'b0;
        acc_flag     = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // single known request and response
        fix_req = 1; fix_rsp = 1; p_req = 100; p_rdy = 100;
        step();
        p_req = 0;
        repeat (8) step();
        fix_req = 0; fix_rsp = 0;

        // fill the buffer with downstream stalled, then release
        p_req = 100; p_rdy = 0;
        repeat (14) step();
        p_rdy = 100;
        repeat (20) step();
        p_req = 0;
        repeat (10) step();

        // second of three responses lost
        rsp_num = 0; drop_at = 2; p_req = 100;
        repeat (3) step();
        p_req = 0;
        repeat (10) step();
        drop_at = 0;

        // spurious response on an idle searcher
        p_spur = 100;
        step();
        p_spur = 0;
        repeat (3) step();

        // init window requested with lookups in flight
        p_req = 100;
        repeat (3) step();
        p_req = 0;
        step();
        cfg_init_req = 1'b1;
        repeat (10) step();
        cfg_init_req = 1'b0;
        p_req = 100;
        repeat (3) step();
        p_req = 0;
        repeat (8) step();

        // random traffic, a reset mid-stream, more random traffic
        p_req = 70; p_rdy = 70; p_drop = 10; p_spur = 5; p_cfg = 10;
        repeat (3000) step();
        do_reset();
        repeat (1500) step();

        p_req = 0; p_drop = 0; p_spur = 0; p_cfg = 0; p_rdy = 100;
        cfg_init_req = 1'b0;
        repeat (40) step();
        @(negedge clk);
        #1;
        chk("end_fwd_valid", fwd_valid, 0);
        chk("end_req_ready", req_ready, 1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
